// File: rtl/srsg_multi.sv
// srsg_multi -- multi-channel shift-register sequence generator for STUMPS BIST.
//
// A Galois LFSR drives CHANNELS scan chains through an XOR phase shifter.
// The block also frames the test: chainLen shift cycles and then one capture
// cycle, repeated patternCount times. It uses a start/done handshake.
//
// Ports:
//   clk, internalRst        clock; asynchronous active-high reset
//   start, abort            run control (abort has priority over start)
//   SRSG_Poly, SRSG_Seed    feedback taps / initial state (sampled on start)
//   chainLen, patternCount  framing (sampled on start)
//   SRSG_Out                scan-in data, one bit per chain
//   shiftEn, captureEn      scan chain control
//   busy, done              run status
//   lfsrState               raw LFSR register

// Per-chain phase shifter tap pair.
module srsg_phase_lane (
  input  logic a_i,
  input  logic b_i,
  output logic y_o
);
  assign y_o = a_i ^ b_i;
endmodule

module srsg_multi #(
  parameter int SRSG_Size = 32,
  parameter int CHANNELS  = 4,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 internalRst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [SRSG_Size-1:0] SRSG_Poly,
  input  logic [SRSG_Size-1:0] SRSG_Seed,
  input  logic [CNT_W-1:0]     chainLen,
  input  logic [CNT_W-1:0]     patternCount,
  output logic [CHANNELS-1:0]  SRSG_Out,
  output logic                 shiftEn,
  output logic                 captureEn,
  output logic                 busy,
  output logic                 done,
  output logic [SRSG_Size-1:0] lfsrState
);

  localparam int HALF = SRSG_Size / 2;

  typedef enum logic [1:0] {IDLE, SHIFT, CAPTURE, DONE} state_t;

  state_t               state_q, state_d;
  logic [SRSG_Size-1:0] lfsr_q, lfsr_d;
  logic [SRSG_Size-1:0] poly_q, poly_d;
  logic [CNT_W-1:0]     shcnt_q, shcnt_d;
  logic [CNT_W-1:0]     patcnt_q, patcnt_d;
  logic [CNT_W-1:0]     len_q, len_d;
  logic [CNT_W-1:0]     npat_q, npat_d;

  logic [SRSG_Size-1:0] lfsr_adv;
  logic [CNT_W-1:0]     patcnt_inc;

  // Galois step: shift left, fold the MSB back through the tap mask.
  assign lfsr_adv   = {lfsr_q[SRSG_Size-2:0], 1'b0}
                    ^ ({SRSG_Size{lfsr_q[SRSG_Size-1]}} & poly_q);
  assign patcnt_inc = patcnt_q + CNT_W'(1);

  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    poly_d   = poly_q;
    shcnt_d  = shcnt_q;
    patcnt_d = patcnt_q;
    len_d    = len_q;
    npat_d   = npat_q;
    if (abort) begin
      // The LFSR keeps its value so that software can read the state where the run stopped.
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            poly_d   = SRSG_Poly;
            lfsr_d   = (SRSG_Seed == '0) ? SRSG_Size'(1) : SRSG_Seed;
            len_d    = (chainLen == '0) ? CNT_W'(1) : chainLen;
            npat_d   = patternCount;
            shcnt_d  = '0;
            patcnt_d = '0;
            state_d  = (patternCount == '0) ? DONE : SHIFT;
          end
        end
        SHIFT: begin
          lfsr_d  = lfsr_adv;
          shcnt_d = shcnt_q + CNT_W'(1);
          if (shcnt_q == len_q - CNT_W'(1)) state_d = CAPTURE;
        end
        CAPTURE: begin
          shcnt_d  = '0;
          patcnt_d = patcnt_inc;
          state_d  = (patcnt_inc == npat_q) ? DONE : SHIFT;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge internalRst) begin
    if (internalRst) begin
      state_q  <= IDLE;
      lfsr_q   <= '0;
      poly_q   <= '0;
      shcnt_q  <= '0;
      patcnt_q <= '0;
      len_q    <= '0;
      npat_q   <= '0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      poly_q   <= poly_d;
      shcnt_q  <= shcnt_d;
      patcnt_q <= patcnt_d;
      len_q    <= len_d;
      npat_q   <= npat_d;
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    srsg_phase_lane u_lane (
      .a_i (lfsr_q[c]),
      .b_i (lfsr_q[c+HALF]),
      .y_o (SRSG_Out[c])
    );
  end

  assign shiftEn   = (state_q == SHIFT);
  assign captureEn = (state_q == CAPTURE);
  assign busy      = (state_q == SHIFT) || (state_q == CAPTURE);
  assign done      = (state_q == DONE);
  assign lfsrState = lfsr_q;

endmodule

// File: tb/tb_srsg_multi.sv
module tb_srsg_multi;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Small instance (8-bit LFSR, 2 chains)
  logic        a_start, a_abort;
  logic [7:0]  a_poly, a_seed;
  logic [15:0] a_len, a_pcnt;
  logic [1:0]  a_out;
  logic        a_sh, a_cap, a_busy, a_done;
  logic [7:0]  a_st;

  // Wide instance (32-bit LFSR, 16 chains)
  logic        b_start, b_abort;
  logic [31:0] b_poly, b_seed;
  logic [15:0] b_len, b_pcnt;
  logic [15:0] b_out;
  logic        b_sh, b_cap, b_busy, b_done;
  logic [31:0] b_st;

  srsg_multi #(.SRSG_Size(8), .CHANNELS(2), .CNT_W(16)) u_a (
    .clk(clk), .internalRst(rst), .start(a_start), .abort(a_abort),
    .SRSG_Poly(a_poly), .SRSG_Seed(a_seed), .chainLen(a_len), .patternCount(a_pcnt),
    .SRSG_Out(a_out), .shiftEn(a_sh), .captureEn(a_cap), .busy(a_busy),
    .done(a_done), .lfsrState(a_st)
  );

  srsg_multi #(.SRSG_Size(32), .CHANNELS(16), .CNT_W(16)) u_b (
    .clk(clk), .internalRst(rst), .start(b_start), .abort(b_abort),
    .SRSG_Poly(b_poly), .SRSG_Seed(b_seed), .chainLen(b_len), .patternCount(b_pcnt),
    .SRSG_Out(b_out), .shiftEn(b_sh), .captureEn(b_cap), .busy(b_busy),
    .done(b_done), .lfsrState(b_st)
  );

  int npass = 0;
  int ntot  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] st8(input logic [7:0] s, input logic [7:0] p);
    return {s[6:0], 1'b0} ^ ({8{s[7]}} & p);
  endfunction

  function automatic logic [31:0] st32(input logic [31:0] s, input logic [31:0] p);
    return {s[30:0], 1'b0} ^ ({32{s[31]}} & p);
  endfunction

  task automatic a_go;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
  endtask

  initial begin
    logic [7:0]  seq [10];
    logic [7:0]  fr;
    logic [7:0]  e8;
    logic [31:0] e32;
    logic [15:0] eo;

    seq = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1D, 8'h3A};
    rst = 1'b1;
    a_start = 0; a_abort = 0; a_poly = 8'h1D; a_seed = 8'h01; a_len = 16'd10; a_pcnt = 16'd1;
    b_start = 0; b_abort = 0; b_poly = 32'h0040_0007; b_seed = 32'hACE1_1234;
    b_len = 16'd1000; b_pcnt = 16'd1;

    // Reset state
    #3;
    chk("rst_lfsr", 32'(a_st), 32'h0);
    chk("rst_out", 32'(a_out), 32'h0);
    chk("rst_ctl", 32'({a_sh, a_cap, a_busy, a_done}), 32'h0);
    chk("rst_b_lfsr", b_st, 32'h0);
    tick();
    rst = 1'b0;
    tick();

    // Sequence: seed 01, chainLen 10, one pattern
    a_go();
    chk("seq_out0", 32'(a_out), 32'h1);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("seq_lfsr%0d", i), 32'(a_st), 32'(seq[i]));
      chk($sformatf("seq_sh%0d", i), 32'({a_sh, a_cap, a_busy}), 32'b101);
      tick();
    end
    chk("seq_cap", 32'({a_sh, a_cap, a_busy}), 32'b011);
    chk("seq_cap_lfsr", 32'(a_st), 32'h74);
    tick();
    chk("seq_done", 32'({a_done, a_busy}), 32'b10);
    chk("seq_done_lfsr", 32'(a_st), 32'h74);

    // Framing: chainLen 3, two patterns -> S S S C S S S C (started from DONE)
    fr = 8'b0111_0111;
    a_seed = 8'hA5; a_len = 16'd3; a_pcnt = 16'd2;
    a_go();
    e8 = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("frm_ctl%0d", i), 32'({a_sh, a_cap, a_busy, a_done}),
          32'({fr[i], ~fr[i], 1'b1, 1'b0}));
      chk($sformatf("frm_lfsr%0d", i), 32'(a_st), 32'(e8));
      if (fr[i]) e8 = st8(e8, 8'h1D);
      tick();
    end
    chk("frm_done", 32'({a_done, a_busy}), 32'b10);

    // Zero seed and chainLen 0, restarting from DONE
    a_seed = 8'h00; a_len = 16'd0; a_pcnt = 16'd1;
    a_go();
    chk("z_lfsr", 32'(a_st), 32'h01);
    chk("z_ctl0", 32'({a_sh, a_cap, a_done}), 32'b100);
    tick();
    chk("z_ctl1", 32'({a_sh, a_cap, a_done}), 32'b010);
    chk("z_lfsr1", 32'(a_st), 32'h02);
    tick();
    chk("z_done", 32'(a_done), 32'h1);

    // patternCount 0: straight to DONE
    a_seed = 8'h33; a_len = 16'd5; a_pcnt = 16'd0;
    a_go();
    chk("p0_ctl", 32'({a_sh, a_cap, a_busy, a_done}), 32'b0001);
    chk("p0_lfsr", 32'(a_st), 32'h33);

    // start during SHIFT ignored, chainLen change ignored
    a_seed = 8'h01; a_len = 16'd4; a_pcnt = 16'd1;
    a_go();
    tick();
    a_start = 1'b1; a_len = 16'd9;
    tick();
    a_start = 1'b0;
    chk("hs_lfsr2", 32'(a_st), 32'h04);
    chk("hs_sh2", 32'(a_sh), 32'h1);
    tick();
    chk("hs_sh3", 32'(a_sh), 32'h1);
    tick();
    chk("hs_cap4", 32'({a_sh, a_cap}), 32'b01);
    tick();
    chk("hs_done5", 32'({a_done, a_busy}), 32'b10);

    // Abort in CAPTURE
    a_seed = 8'h81; a_len = 16'd1; a_pcnt = 16'd2;
    a_go();
    chk("ab_sh", 32'(a_sh), 32'h1);
    tick();
    chk("ab_cap", 32'(a_cap), 32'h1);
    a_abort = 1'b1;
    tick();
    a_abort = 1'b0;
    chk("ab_ctl", 32'({a_sh, a_cap, a_busy, a_done}), 32'b0000);
    chk("ab_lfsr", 32'(a_st), 32'h1F);

    // abort together with start stays in IDLE
    a_seed = 8'h44; a_len = 16'd2; a_pcnt = 16'd1;
    a_start = 1'b1; a_abort = 1'b1;
    tick();
    a_start = 1'b0; a_abort = 1'b0;
    chk("abs_ctl", 32'({a_sh, a_cap, a_busy, a_done}), 32'b0000);
    chk("abs_lfsr", 32'(a_st), 32'h1F);
    tick();
    chk("abs_ctl2", 32'(a_busy), 32'h0);

    // Asynchronous reset in the middle of SHIFT
    a_seed = 8'h01; a_len = 16'd10; a_pcnt = 16'd1;
    a_go();
    tick();
    tick();
    chk("ar_pre", 32'({a_sh, a_st}), 32'h104);
    #2 rst = 1'b1;
    #1;
    chk("ar_lfsr", 32'(a_st), 32'h0);
    chk("ar_out", 32'(a_out), 32'h0);
    chk("ar_ctl", 32'({a_sh, a_cap, a_busy, a_done}), 32'b0000);
    tick();
    rst = 1'b0;
    tick();

    // Wide configuration: 1000 shifts against a reference model
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    e32 = 32'hACE1_1234;
    for (int i = 0; i < 1000; i++) begin
      for (int c = 0; c < 16; c++) eo[c] = e32[c] ^ e32[c+16];
      chk("sw_lfsr", b_st, e32);
      chk("sw_out", 32'(b_out), 32'(eo));
      chk("sw_sh", 32'(b_sh), 32'h1);
      e32 = st32(e32, 32'h0040_0007);
      tick();
    end
    chk("sw_cap", 32'({b_sh, b_cap}), 32'b01);
    chk("sw_cap_lfsr", b_st, e32);
    tick();
    chk("sw_done", 32'({b_done, b_busy}), 32'b10);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
